// File: rtl/dram_stream_reader_pkg.sv
// Shared sizing constants and control-state encoding for the DRAM streaming blocks.
package dram_stream_reader_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head, full/empty flags and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dram_stream_reader.sv
// Reads a block of words from the dram_256x16 read port and streams them out with valid/ready,
// issuing reads only while the output buffer has room for them.
module dram_stream_reader #(
  parameter int ADDR_WIDTH = dram_stream_reader_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = dram_stream_reader_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = dram_stream_reader_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  import dram_stream_reader_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = ADDR_WIDTH + 1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         rd_left_q;
  logic [LW-1:0]         out_left_q;
  logic                  pend_q;
  logic                  done_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [CW:0]           credit_used;
  logic                  re_int;
  logic                  last_int;
  logic                  pop;

  // A read is only issued if its word is guaranteed a FIFO slot when it lands.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, pend_q};
  assign re_int      = (state_q == READ) && (rd_left_q != '0) && !fifo_full &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign last_int    = !fifo_empty && (out_left_q == LW'(1));
  assign pop         = m_valid && m_ready;

  assign busy      = !rst && (state_q != IDLE);
  assign done      = !rst && done_q;
  assign ram_re    = !rst && re_int;
  assign ram_raddr = rst ? '0 : addr_q;
  assign m_valid   = !rst && !fifo_empty;
  assign m_last    = !rst && last_int;
  assign m_data    = m_valid ? fifo_rdata : '0;

  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_left_q  <= '0;
      out_left_q <= '0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pend_q <= re_int;
      if (re_int) begin
        addr_q    <= addr_q + 1'b1;
        rd_left_q <= rd_left_q - 1'b1;
      end
      if (pop) out_left_q <= out_left_q - 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q     <= base_addr;
              rd_left_q  <= len;
              out_left_q <= len;
              state_q    <= READ;
            end
          end
        end
        READ:    if (re_int && (rd_left_q == LW'(1))) state_q <= DRAIN;
        DRAIN: begin
          if (pop && last_int) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (pend_q),
    .wdata(ram_q),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_dram_stream_reader.sv
// Directed bench for dram_stream_reader: behavioural RAM, transfer-level scoreboard, literal spot checks.
module tb_dram_stream_reader;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, ram_re, m_valid, m_ready, m_last;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] m_data;

  logic [DW-1:0] mem [256];
  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic          busy_m = 1'b0, done_m = 1'b0, busy_n, done_n;
  logic [AW-1:0] rd_addr_m;
  int            rd_left_m = 0, reads_m = 0, hs_m = 0, start_cyc = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  word_t         w;

  logic [DW-1:0] hs_data[$];
  logic          hs_last[$];
  int            hs_rel[$];
  logic [AW-1:0] addr_log[$];
  int            done_rel[$];

  dram_stream_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .ram_re   (ram_re),
    .ram_raddr(ram_raddr),
    .ram_q    (ram_q),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int a = 0; a < 256; a++) mem[a] = DW'(a * 'h0101);
  always @(posedge clk) if (ram_re) ram_q <= mem[ram_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: expected word list per accepted start, address sequence, done/busy timing.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ram_re", ram_re, 0);
      check("rst_raddr", ram_raddr, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_m_data", m_data, 0);
      exp_q.delete();
      busy_m = 1'b0; done_m = 1'b0; prev_stall = 1'b0;
      rd_left_m = 0; reads_m = 0; hs_m = 0;
    end else begin
      check("busy", busy, busy_m);
      check("done", done, done_m);
      if (done) done_rel.push_back(cyc - start_cyc);
      done_n = 1'b0;
      busy_n = busy_m;
      if (ram_re) begin
        check("re_inside_transfer", rd_left_m > 0, 1);
        check("raddr", ram_raddr, rd_addr_m);
        addr_log.push_back(ram_raddr);
        rd_addr_m = rd_addr_m + 1'b1;
        rd_left_m--;
        reads_m++;
        check("outstanding_le_depth", (reads_m - hs_m) <= FD, 1);
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", m_valid, 0);
        end else begin
          check("m_data", m_data, exp_q[0].data);
          check("m_last", m_last, exp_q[0].last);
          if (m_ready) begin
            w = exp_q.pop_front();
            hs_m++;
            hs_data.push_back(m_data);
            hs_last.push_back(m_last);
            hs_rel.push_back(cyc - start_cyc);
            if (w.last) begin
              busy_n = 1'b0;
              done_n = 1'b1;
            end
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (start && !busy_m) begin
        start_cyc = cyc;
        reads_m = 0;
        hs_m = 0;
        if (len == 0) begin
          done_n = 1'b1;
        end else begin
          busy_n    = 1'b1;
          rd_addr_m = base_addr;
          rd_left_m = int'(len);
          for (int i = 0; i < int'(len); i++) begin
            w.data = mem[AW'(int'(base_addr) + i)];
            w.last = (i == int'(len) - 1);
            exp_q.push_back(w);
          end
        end
      end
      busy_m = busy_n;
      done_m = done_n;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
    hs_data.delete(); hs_last.delete(); hs_rel.delete(); addr_log.delete(); done_rel.delete();
    base_addr = b;
    len       = l;
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_rel.size() == 0 && n < max_cyc) begin
      step(1);
      n++;
    end
    check("done_seen", done_rel.size() > 0, 1);
  endtask

  logic [AW-1:0] t2_addr [4];
  logic [DW-1:0] t2_word [4];
  int            n;

  initial begin
    t2_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    t2_word = '{16'hFEFE, 16'hFFFF, 16'h0000, 16'h0101};
    rst = 1'b1; start = 1'b0; m_ready = 1'b1; base_addr = '0; len = '0;
    step(3);
    rst = 1'b0;

    // Basic transfer, started in the first cycle out of reset.
    do_start(8'h10, 9'd4);
    wait_done(30);
    check("t1_count", hs_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t1_word", hs_data[i], 16'h1010 + 16'(i) * 16'h0101);
      check("t1_cycle", hs_rel[i], 3 + i);
    end
    check("t1_last", hs_last[3], 1);
    check("t1_done_cycle", done_rel[0], 7);
    step(2);

    // Address wrap.
    do_start(8'hFE, 9'd4);
    wait_done(30);
    check("t2_reads", addr_log.size(), 4);
    check("t2_count", hs_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_raddr", addr_log[i], t2_addr[i]);
      check("t2_word", hs_data[i], t2_word[i]);
    end
    step(2);

    // Full-length transfer with m_ready toggling every cycle.
    do_start(8'h00, 9'd256);
    n = 0;
    while (done_rel.size() == 0 && n < 2000) begin
      m_ready = ~m_ready;
      step(1);
      n++;
    end
    m_ready = 1'b1;
    check("t3_done_seen", done_rel.size() > 0, 1);
    check("t3_count", hs_data.size(), 256);
    check("t3_word_255", hs_data[255], 16'hFFFF);
    step(2);

    // Zero length.
    do_start(8'h33, 9'd0);
    wait_done(10);
    check("t4_done_cycle", done_rel[0], 1);
    check("t4_reads", addr_log.size(), 0);
    check("t4_words", hs_data.size(), 0);
    step(2);

    // Long downstream stall mid-transfer.
    do_start(8'h80, 9'd16);
    n = 0;
    while (hs_data.size() < 5 && n < 50) begin
      step(1);
      n++;
    end
    m_ready = 1'b0;
    step(20);
    check("t5_reads_during_stall", (addr_log.size() - hs_data.size()) <= FD, 1);
    m_ready = 1'b1;
    wait_done(60);
    check("t5_count", hs_data.size(), 16);
    check("t5_last_word", hs_data[15], 16'h8F8F);
    step(2);

    // Reset after word 3 of a 10-word transfer, then a fresh transfer.
    do_start(8'h20, 9'd10);
    n = 0;
    while (hs_data.size() < 3 && n < 50) begin
      step(1);
      n++;
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_words_before_rst", hs_data.size(), 3);
    check("t6_no_done", done_rel.size(), 0);
    do_start(8'h40, 9'd2);
    wait_done(30);
    check("t6_count", hs_data.size(), 2);
    check("t6_word0", hs_data[0], 16'h4040);
    check("t6_word1", hs_data[1], 16'h4141);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
